// File: rtl/alu_pkg.sv
// Shared opcode/state types and latency constants for the multicycle ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_OR   = 5'd0,
        OP_AND  = 5'd1,
        OP_NOT  = 5'd2,
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_SHR  = 5'd5,
        OP_SHRA = 5'd6,
        OP_SHL  = 5'd7,
        OP_ROR  = 5'd8,
        OP_ROL  = 5'd9,
        OP_NEG  = 5'd10,
        OP_MUL  = 5'd11,
        OP_DIV  = 5'd12
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DIV_FIX,
        ST_DONE
    } state_t;

    localparam logic [4:0] OP_LAST = 5'd12;

    // Cycles from the accepting clock edge's start cycle to the done cycle.
    function automatic int MUL_LAT(input int width);
        return width + 1;
    endfunction

    function automatic int DIV_LAT(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide sharing one
// accumulator, shift register and step counter; DIV adds a sign-fix cycle.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic             run_q, run_d;
    logic             fix_q, fix_d;
    logic             div_q, div_d;
    logic             qm1_q, qm1_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] m_q, m_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   mul_acc;
    logic [WIDTH-1:0] mul_sh;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // The accumulator carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow during a Booth step.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({sh_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        mul_acc  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_sh   = {booth_sum[0], sh_q[WIDTH-1:1]};
        rem_sh   = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
    end

    assign last_o = run_q && (cnt_q == '0);
    assign done_o = (last_o && !div_q) || fix_q;
    assign lo_o   = fix_q ? (qneg_q ? -sh_q : sh_q) : mul_sh;
    assign hi_o   = fix_q ? (rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])
                          : mul_acc[WIDTH-1:0];

    always_comb begin
        run_d  = run_q;
        fix_d  = 1'b0;
        div_d  = div_q;
        qm1_d  = qm1_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sh_d   = sh_q;
        m_d    = m_q;
        if (start_i && !run_q && !fix_q) begin
            run_d  = 1'b1;
            div_d  = div_i;
            cnt_d  = CNT_INIT;
            acc_d  = '0;
            qm1_d  = 1'b0;
            qneg_d = div_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_d = div_i & a_i[WIDTH-1];
            sh_d   = div_i ? mag(a_i) : b_i;
            m_d    = div_i ? mag(b_i) : a_i;
        end else if (run_q) begin
            cnt_d = cnt_q - 1'b1;
            if (div_q) begin
                if (!rem_diff[WIDTH]) begin
                    acc_d = rem_diff;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = mul_acc;
                sh_d  = mul_sh;
                qm1_d = sh_q[0];
            end
            if (last_o) begin
                run_d = 1'b0;
                fix_d = div_q;
            end
        end
    end

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            run_q  <= 1'b0;
            fix_q  <= 1'b0;
            div_q  <= 1'b0;
            qm1_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            m_q    <= '0;
        end else begin
            run_q  <= run_d;
            fix_q  <= fix_d;
            div_q  <= div_d;
            qm1_q  <= qm1_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            m_q    <= m_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with single-cycle ops and iterative signed MUL/DIV behind start/busy/done.
// Define ALU_MULTICYCLE_FLAGS_EN to add the registered flag_z/n/c/v outputs.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
`ifdef ALU_MULTICYCLE_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_lo_q, result_lo_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             div_zero_q, div_zero_d;

    logic             core_start;
    logic             core_div;
    logic             core_last;
    logic             core_done;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] core_hi;

    logic [SHW-1:0]   shamt;
    int               sh_i;
    logic [WIDTH-1:0] sc_lo;

    assign shamt    = B[SHW-1:0];
    assign sh_i     = int'(shamt);
    assign core_div = (op == OP_DIV);

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clock_i (clock),
        .clear_i (clear),
        .start_i (core_start),
        .div_i   (core_div),
        .a_i     (A),
        .b_i     (B),
        .last_o  (core_last),
        .done_o  (core_done),
        .lo_o    (core_lo),
        .hi_o    (core_hi)
    );

    always_comb begin
        sc_lo = '0;
        if (op <= OP_LAST) begin
            case (op)
                OP_OR:   sc_lo = A | B;
                OP_AND:  sc_lo = A & B;
                OP_NOT:  sc_lo = ~A;
                OP_ADD:  sc_lo = A + B;
                OP_SUB:  sc_lo = A - B;
                OP_SHR:  sc_lo = A >> shamt;
                OP_SHRA: sc_lo = $signed(A) >>> shamt;
                OP_SHL:  sc_lo = A << shamt;
                OP_ROR:  sc_lo = (A >> shamt) | (A << (WIDTH - sh_i));
                OP_ROL:  sc_lo = (A << shamt) | (A >> (WIDTH - sh_i));
                OP_NEG:  sc_lo = -A;
                default: sc_lo = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        div_zero_d  = div_zero_q;
        core_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    state_d    = ST_DONE;
                    if (op == OP_MUL) begin
                        core_start = 1'b1;
                        state_d    = ST_MUL;
                    end else if (op == OP_DIV && B == '0) begin
                        result_lo_d = '1;
                        result_hi_d = A;
                        div_zero_d  = 1'b1;
                    end else if (op == OP_DIV) begin
                        core_start = 1'b1;
                        state_d    = ST_DIV;
                    end else begin
                        result_lo_d = sc_lo;
                        result_hi_d = '0;
                    end
                end
            end
            ST_MUL: begin
                if (core_done) begin
                    result_lo_d = core_lo;
                    result_hi_d = core_hi;
                    state_d     = ST_DONE;
                end
            end
            ST_DIV: begin
                if (core_last) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                if (core_done) begin
                    result_lo_d = core_lo;
                    result_hi_d = core_hi;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            result_lo_q <= '0;
            result_hi_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_DIV_FIX);
    assign done      = (state_q == ST_DONE);
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign div_zero  = div_zero_q;

`ifdef ALU_MULTICYCLE_FLAGS_EN
    localparam logic [SHW-1:0] W_MOD = SHW'(WIDTH);

    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    logic flag_c_q, flag_c_d;
    logic flag_v_q, flag_v_d;
    logic sc_c, sc_v;
    logic a_m, b_m, r_m;
    logic sh_ok;

    assign a_m   = A[WIDTH-1];
    assign b_m   = B[WIDTH-1];
    assign r_m   = sc_lo[WIDTH-1];
    assign sh_ok = (shamt != '0) && (sh_i <= WIDTH);

    // Carry out of the MSB recovered from the operand and sum sign bits.
    always_comb begin
        sc_c = 1'b0;
        sc_v = 1'b0;
        case (op)
            OP_ADD: begin
                sc_c = (a_m & b_m) | ((a_m ^ b_m) & ~r_m);
                sc_v = (a_m == b_m) && (r_m != a_m);
            end
            OP_SUB: begin
                sc_c = (a_m & ~b_m) | (~(a_m ^ b_m) & ~r_m);
                sc_v = (a_m != b_m) && (r_m != a_m);
            end
            OP_NEG: begin
                sc_c = (A == '0);
                sc_v = a_m & r_m;
            end
            OP_SHR, OP_SHRA, OP_ROR: sc_c = sh_ok ? A[shamt - 1'b1] : 1'b0;
            OP_SHL, OP_ROL:          sc_c = sh_ok ? A[W_MOD - shamt] : 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        if (state_q == ST_IDLE && start && !core_start) begin
            flag_z_d = (result_lo_d == '0);
            flag_n_d = result_lo_d[WIDTH-1];
            flag_c_d = sc_c;
            flag_v_d = sc_v;
        end else if (core_done && (state_q == ST_MUL || state_q == ST_DIV_FIX)) begin
            flag_z_d = (result_lo_d == '0);
            flag_n_d = result_lo_d[WIDTH-1];
            flag_c_d = 1'b0;
            flag_v_d = (state_q == ST_MUL) && (result_hi_d != {WIDTH{result_lo_d[WIDTH-1]}});
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
`endif

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the Phase 1 combinational ALU.
- Keeps the single-cycle logic/arithmetic ops and adds shifts, rotates and negate.
- Adds iterative signed multiply (HI/LO) and signed divide (quotient/remainder) behind a start/busy/done handshake.
- Sits between the register-file operand latches (A, B) and the Z/HI/LO datapath registers; the control unit sequences it.

Parameters:
- WIDTH, 32, operand and result width; any even value >= 8.
- SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  5  opcode; sampled with start
- A  in  WIDTH  operand A; sampled with start
- B  in  WIDTH  operand B; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; results valid from this cycle on
- result_lo  out  WIDTH  main result / product low / quotient
- result_hi  out  WIDTH  product high / remainder; 0 for other ops
- div_zero  out  1  set when the completed DIV had B==0

Behaviour:
- Interface: one clock (clock); reset clear is asynchronous and active-high.
- Reset: asynchronous. busy=0, done=0, result_lo=0, result_hi=0, div_zero=0, FSM=IDLE. Reset mid-operation aborts it; no done is issued.
- Opcodes:
  - 0 OR, 1 AND, 2 NOT A, 3 ADD, 4 SUB (A-B).
  - 5 SHR (logical), 6 SHRA (arithmetic), 7 SHL, 8 ROR, 9 ROL; shift/rotate amount = B[SHW-1:0], upper bits ignored.
  - 10 NEG (0-A), 11 MUL (signed), 12 DIV (signed).
  - 13..31: result 0, single-cycle.
- Arithmetic: ADD/SUB/NEG wrap modulo 2^WIDTH.
- FSM states: IDLE, MUL, DIV, DIV_FIX, DONE.
- Single-cycle ops (and DIV with B==0): start seen at edge k -> results registered at edge k; done=1 for the cycle after edge k; FSM passes through DONE to IDLE. busy stays 0.
- MUL:
  - Radix-2 Booth, one step per clock; busy=1 from edge k.
  - Step counter runs WIDTH-1 down to 0.
  - After WIDTH steps the product is registered at edge k+WIDTH; done pulses the following cycle, busy drops with it.
  - {result_hi,result_lo} = full 2*WIDTH signed product.
- DIV:
  - Operands converted to magnitude at edge k.
  - WIDTH restoring steps, then DIV_FIX applies signs at edge k+WIDTH+1; done pulses the following cycle.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1: result_lo = most-negative, result_hi = 0.
- Divide by zero: result_lo = all ones, result_hi = A, div_zero=1, single-cycle latency.
- div_zero clears on the next accepted start.
- Handshake:
  - start while busy=1 or done=1 is ignored; op/A/B may change freely during busy.
  - Results hold their value until the next accepted start.
- start asserted in the same cycle as done is ignored; accepts resume from IDLE the cycle after.

Optional Feature:
- Macro ALU_MULTICYCLE_FLAGS_EN.
- Defined: adds output ports flag_z, flag_n, flag_c, flag_v, all 1 bit.
  - Registered with result_lo; reset 0.
  - z = result_lo==0; n = result_lo[WIDTH-1].
  - c = carry out for ADD, NOT borrow for SUB/NEG, last bit shifted out for shifts, else 0.
  - v = signed overflow for ADD/SUB/NEG; for MUL, set when result_hi is not the sign-extension of result_lo; else 0.
- Undefined: ports absent; no flag logic.

Decomposition:
- Package alu_pkg holds:
  - the op_t enum (5-bit, the values above);
  - the state_t enum;
  - localparams OP_LAST=12, MUL_LAT(WIDTH)=WIDTH+1, DIV_LAT(WIDTH)=WIDTH+2 (latency in cycles from start to done).
- Sub-module alu_muldiv_core, shared between MUL and DIV:
  - shared accumulator, shift register, step counter;
  - sign-fix datapath;
  - its own start/done handshake.
- Top level holds the single-cycle ops, the FSM and the output registers.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 -> done one cycle later, result_lo=0x80000000, result_hi=0; with flags, v=1, n=1.
- SHRA A=0x80000010, B=0x24 (amount 4) -> 0xF8000001; ROL A=0x80000001, B=1 -> 0x00000003.
- MUL -7 * 6 -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFD6; start pulses during busy are ignored.
- DIV -17 / 5 -> done at 34 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIV 9/0 -> done after 1 cycle, lo=0xFFFFFFFF, hi=9, div_zero=1. Next ADD start clears div_zero.
- Assert clear 10 cycles into a MUL -> all outputs 0 immediately, no done. A new ADD after release completes normally.
